// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-TX state encoding, frame geometry, default
// timing constants and the odd-parity helper used by both TX and RX paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_ACK       = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } ps2_state_e;

    localparam int PS2_FRAME_BITS      = 11;
    localparam int PS2_DATA_BITS       = 8;
    localparam int PS2_INHIBIT_DEFAULT = 5000;
    localparam int PS2_TIMEOUT_DEFAULT = 750000;

    // PS/2 parity bit makes the total count of ones odd
    function automatic logic ps2_odd_parity(input logic [7:0] byte_i);
        return ~^byte_i;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one open-drain PS/2 line with a gated
// falling-edge pulse; shared by the host transmitter and keyboard receiver.
module ps2_line_sync (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic line_i,
    input  logic en_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle bus is high, so reset to 1 to avoid a false edge after reset
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = en_i & prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request, 11-bit frame).
// Define PS2_TX_ACK_CHECK_EN to turn a missing device ACK into tx_error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_DEFAULT,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       PS2_clk_in,
    input  logic       PS2_data_in,
    output logic       PS2_clk_oe,
    output logic       PS2_data_oe
);

    localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int EW      = $clog2(PS2_FRAME_BITS + 1);

    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [EW-1:0] DATA_LAST = EW'(PS2_DATA_BITS - 1);
    localparam logic [EW-1:0] ACK_EDGE  = EW'(PS2_FRAME_BITS - 1);

    ps2_state_e    state_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [EW-1:0] edge_cnt_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clk_oe_q;
    logic          data_oe_q;
    logic          ready_q;
    logic          done_q;
    logic          error_q;

    logic clk_lvl_s;
    logic clk_fall_s;
    logic data_lvl_s;
    logic unused_data_fall_s;
    logic edge_en_s;
    logic frame_live_s;
    logic tmo_hit_s;

    assign edge_en_s    = (state_q inside {ST_DATA, ST_PARITY, ST_STOP, ST_ACK});
    assign frame_live_s = (state_q inside {ST_DATA, ST_PARITY, ST_STOP, ST_ACK, ST_WAIT_IDLE});
    assign cnt_d        = cnt_q + 1'b1;
    assign tmo_hit_s    = (cnt_d == TMO_LIMIT);

    ps2_line_sync u_clk_sync (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .line_i    (PS2_clk_in),
        .en_i      (edge_en_s),
        .level_o   (clk_lvl_s),
        .fall_o    (clk_fall_s)
    );

    ps2_line_sync u_data_sync (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .line_i    (PS2_data_in),
        .en_i      (1'b0),
        .level_o   (data_lvl_s),
        .fall_o    (unused_data_fall_s)
    );

    // Transmit FSM; all line drives and handshakes are registered here
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            edge_cnt_q <= '0;
            cnt_q      <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (frame_live_s) begin
                cnt_q <= cnt_d;
            end
            // The timeout wins over any edge seen in the same cycle
            if (frame_live_s && tmo_hit_s) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                error_q   <= 1'b1;
                ready_q   <= 1'b1;
                state_q   <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        if (tx_valid && ready_q) begin
                            shift_q    <= tx_data;
                            parity_q   <= ps2_odd_parity(tx_data);
                            cnt_q      <= '0;
                            edge_cnt_q <= '0;
                            clk_oe_q   <= 1'b1;
                            ready_q    <= 1'b0;
                            state_q    <= ST_INHIBIT;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end
                    ST_INHIBIT: begin
                        if (cnt_q == INH_LAST) begin
                            data_oe_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= ST_REQ;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_REQ: begin
                        clk_oe_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (clk_fall_s) begin
                            data_oe_q  <= ~shift_q[0];
                            shift_q    <= {1'b0, shift_q[7:1]};
                            edge_cnt_q <= edge_cnt_q + 1'b1;
                            if (edge_cnt_q == DATA_LAST) begin
                                state_q <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (clk_fall_s) begin
                            data_oe_q  <= ~parity_q;
                            edge_cnt_q <= edge_cnt_q + 1'b1;
                            state_q    <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (clk_fall_s) begin
                            data_oe_q  <= 1'b0;
                            edge_cnt_q <= edge_cnt_q + 1'b1;
                            state_q    <= ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        if (clk_fall_s && (edge_cnt_q == ACK_EDGE)) begin
                            edge_cnt_q <= edge_cnt_q + 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
                            if (data_lvl_s) begin
                                clk_oe_q  <= 1'b0;
                                data_oe_q <= 1'b0;
                                error_q   <= 1'b1;
                                ready_q   <= 1'b1;
                                state_q   <= ST_IDLE;
                            end else begin
                                state_q <= ST_WAIT_IDLE;
                            end
`else
                            state_q <= ST_WAIT_IDLE;
`endif
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (clk_lvl_s && data_lvl_s) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        ready_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign PS2_clk_oe  = clk_oe_q;
    assign PS2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model
// clocking every 20 cycles; honours PS2_TX_ACK_CHECK_EN when defined.
module tb_ps2_host_tx;

`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       PS2_clk_in;
    logic       PS2_data_in;
    logic       PS2_clk_oe;
    logic       PS2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign PS2_clk_in  = ~PS2_clk_oe & dev_clk;
    assign PS2_data_in = ~PS2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(2000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .PS2_clk_in  (PS2_clk_in),
        .PS2_data_in (PS2_data_in),
        .PS2_clk_oe  (PS2_clk_oe),
        .PS2_data_oe (PS2_data_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] frame;
        logic        exp_done;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       nack;
        logic       par;
        logic       exp_done;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[4];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int inh_tot = 0;
    int req_tot = 0;
    int last_done_cyc = 0;
    int err_cyc = 0;
    int fall_cyc = 0;
    int accept_cyc = 0;
    logic clk_oe_prev = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (reset_n && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        if (tx_done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (tx_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        if (PS2_clk_oe && !PS2_data_oe) inh_tot <= inh_tot + 1;
        if (PS2_clk_oe && PS2_data_oe) req_tot <= req_tot + 1;
        if (clk_oe_prev && !PS2_clk_oe) fall_cyc <= cyc;
        clk_oe_prev <= PS2_clk_oe;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic par, input logic ed);
        exp_t e;
        e.frame    = {1'b1, par, d, 1'b0};
        e.exp_done = ed;
        exp_q.push_back(e);
    endtask

    task automatic do_request(input logic [7:0] d, input bit keep);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        chk("req_ready_wait", tx_ready, 1);
        @(posedge clk);
        @(negedge clk);
        accept_cyc = cyc;
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic device_frame(input bit ack_low, input int nclk, output logic [10:0] bits);
        bits = '0;
        for (int i = 0; i < 100; i++) begin
            if (!PS2_clk_oe) break;
            @(negedge clk);
        end
        chk("clk_release_wait", PS2_clk_oe, 0);
        bits[0] = PS2_data_in;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && ack_low) dev_data = 1'b0;
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) bits[k] = PS2_data_in;
            if (k == 11) begin
                dev_data = 1'b1;
            end else begin
                repeat (10) @(negedge clk);
            end
        end
    endtask

    task automatic wait_outcome(input int bd, input int be, output logic gd, output logic ge);
        for (int i = 0; i < 60; i++) begin
            if (done_cnt != bd || err_cnt != be) break;
            @(negedge clk);
        end
        @(negedge clk);
        gd = (done_cnt == bd + 1);
        ge = (err_cnt == be + 1);
    endtask

    task automatic check_pop(input logic [10:0] bits, input logic gd, input logic ge);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            chk("frame_bits", bits, e.frame);
            chk("done_pulse", gd, e.exp_done);
            chk("error_pulse", ge, !e.exp_done);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [10:0] bits;
        logic gd, ge;
        int bd, be, bi, br;
        bd = done_cnt; be = err_cnt; bi = inh_tot; br = req_tot;
        push_exp(v.data, v.par, v.exp_done);
        do_request(v.data, 1'b0);
        device_frame(!v.nack, 11, bits);
        wait_outcome(bd, be, gd, ge);
        check_pop(bits, gd, ge);
        chk("inhibit_len", inh_tot - bi, 10);
        chk("req_len", req_tot - br, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] bits1, bits2;
        logic gd, ge;
        int bd, be, ab;

        vecs[0] = '{data: 8'hED, nack: 1'b0, par: 1'b1, exp_done: 1'b1};
        vecs[1] = '{data: 8'h80, nack: 1'b0, par: 1'b0, exp_done: 1'b1};
        vecs[2] = '{data: 8'h3C, nack: 1'b0, par: 1'b1, exp_done: 1'b1};
        vecs[3] = '{data: 8'hA5, nack: 1'b1, par: 1'b1, exp_done: !ACK_CHECK};

        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_clk_oe", PS2_clk_oe, 0);
        chk("rst_data_oe", PS2_data_oe, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_error", tx_error, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // back-to-back 0x01 then 0xFF
        bd = done_cnt; be = err_cnt;
        push_exp(8'h01, 1'b0, 1'b1);
        do_request(8'h01, 1'b0);
        device_frame(1'b1, 11, bits1);
        push_exp(8'hFF, 1'b1, 1'b1);
        do_request(8'hFF, 1'b0);
        chk("b2b_accept_gap", accept_cyc - last_done_cyc, 1);
        check_pop(bits1, done_cnt == bd + 1, err_cnt != be);
        bd = done_cnt; be = err_cnt;
        device_frame(1'b1, 11, bits2);
        wait_outcome(bd, be, gd, ge);
        check_pop(bits2, gd, ge);

        // tx_valid held through the frame with a changing tx_data
        bd = done_cnt; be = err_cnt; ab = acc_cnt;
        push_exp(8'h55, 1'b1, 1'b1);
        do_request(8'h55, 1'b1);
        tx_data = 8'h0F;
        device_frame(1'b1, 11, bits1);
        tx_valid = 1'b0;
        wait_outcome(bd, be, gd, ge);
        check_pop(bits1, gd, ge);
        repeat (5) @(negedge clk);
        chk("single_accept", acc_cnt - ab, 1);

        // reset pulse mid-frame after bit 3
        bd = done_cnt; be = err_cnt;
        do_request(8'h00, 1'b0);
        device_frame(1'b1, 3, bits1);
        chk("pre_reset_data_oe", PS2_data_oe, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_clk_oe", PS2_clk_oe, 0);
        chk("mid_rst_data_oe", PS2_data_oe, 0);
        chk("mid_rst_ready", tx_ready, 1);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - bd, 0);
        chk("mid_rst_no_error", err_cnt - be, 0);

        // device never clocks: timeout
        bd = done_cnt; be = err_cnt;
        do_request(8'h3C, 1'b0);
        for (int i = 0; i < 2200; i++) begin
            if (err_cnt != be) break;
            @(negedge clk);
        end
        chk("tmo_error_count", err_cnt - be, 1);
        chk("tmo_no_done", done_cnt - bd, 0);
        chk("tmo_latency", err_cyc - fall_cyc, 2000);
        chk("tmo_clk_oe", PS2_clk_oe, 0);
        chk("tmo_data_oe", PS2_data_oe, 0);
        chk("tmo_ready", tx_ready, 1);

        chk("no_double_pulse", both_cnt, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
